weights_loader: RTL and testbench

Consumer end of the weight-generation path: accepts packed random weight vectors of `ELEMENT_WIDTH*NO_OF_RAND_ELEMENTS` bits over a valid/ready handshake. Each accepted vector is serialized into one-element-per-cycle writes to a weight matrix RAM, filling the matrix row-major. It raises `all_finish` once the whole `NO_OF_ROWS x NO_OF_COLUMNS` matrix is stored. The top module has two instances: input_hidden and hidden_output weights.

---
 rtl/weights_pkg.sv | 15 +
 rtl/weights_loader_if.sv | 25 ++
 rtl/weight_vector_serializer.sv | 40 ++++
 rtl/weights_loader.sv | 118 +++++++++++
 tb/tb_weights_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weights_pkg.sv
// Shared defaults and loader state encoding for the weight-generation path.
package weights_pkg;
  localparam int DEF_ELEMENT_WIDTH       = 32;
  localparam int DEF_NO_OF_RAND_ELEMENTS = 16;
  localparam int DEF_NO_OF_ROWS          = 64;
  localparam int DEF_NO_OF_COLUMNS       = 64;
  localparam int DEF_ADDR_WIDTH          = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } loader_state_e;
endpackage

// File: rtl/weights_loader_if.sv
// Vector handshake plus RAM write port of the weights loader; slave = loader side.
interface weights_loader_if #(
  parameter int EW = 32,
  parameter int NE = 16,
  parameter int AW = 12
);
  logic [EW*NE-1:0] in_vector;
  logic             in_valid;
  logic             in_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [EW-1:0]    mem_wdata;
  logic             all_finish;
  logic [EW-1:0]    checksum;

  modport master (
    output in_vector, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, all_finish, checksum
  );

  modport slave (
    input  in_vector, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, all_finish, checksum
  );
endinterface

// File: rtl/weight_vector_serializer.sv
// Holds one captured weight vector and steps through its elements, LSB element first.
module weight_vector_serializer
  import weights_pkg::*;
#(
  parameter int EW = DEF_ELEMENT_WIDTH,
  parameter int NE = DEF_NO_OF_RAND_ELEMENTS
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [EW*NE-1:0] vec,
  output logic [EW-1:0]    elem,
  output logic             last
);
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  logic [NE-1:0][EW-1:0] vec_q;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;

  assign idx_nxt = idx + 1'b1;
  assign last    = (idx == IW'(NE-1));

  // elem is a register so the RAM write data leaves the block straight from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q <= '0;
      idx   <= '0;
      elem  <= '0;
    end else if (load) begin
      vec_q <= vec;
      idx   <= '0;
      elem  <= vec[EW-1:0];
    end else if (advance && !last) begin
      idx  <= idx_nxt;
      elem <= vec_q[idx_nxt];
    end
  end
endmodule

// File: rtl/weights_loader.sv
// Serializes accepted weight vectors into row-major RAM writes and flags matrix completion.
// Optional running checksum of written words: define WEIGHTS_LOADER_CHECKSUM_EN.
module weights_loader
  import weights_pkg::*;
#(
  parameter int ELEMENT_WIDTH       = DEF_ELEMENT_WIDTH,
  parameter int NO_OF_RAND_ELEMENTS = DEF_NO_OF_RAND_ELEMENTS,
  parameter int NO_OF_ROWS          = DEF_NO_OF_ROWS,
  parameter int NO_OF_COLUMNS       = DEF_NO_OF_COLUMNS,
  parameter int ADDR_WIDTH          = DEF_ADDR_WIDTH
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  weights_loader_if.slave  bus
);
  localparam int TOTAL = NO_OF_ROWS * NO_OF_COLUMNS;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACCEPT = 2'(ACCEPT);
  localparam logic [1:0] ST_WRITE  = 2'(WRITE);
  localparam logic [1:0] ST_DONE   = 2'(DONE);

  logic [1:0]               state;
  logic [ADDR_WIDTH-1:0]    wcnt;
  logic                     in_ready_q;
  logic                     mem_we_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;
  logic                     all_finish_q;
  logic [ELEMENT_WIDTH-1:0] elem;
  logic                     last;
  logic                     accept;
  logic                     advance;

  assign accept  = bus.in_valid & in_ready_q & enable;
  assign advance = (state == ST_WRITE) & enable;

  weight_vector_serializer #(
    .EW (ELEMENT_WIDTH),
    .NE (NO_OF_RAND_ELEMENTS)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .advance (advance),
    .vec     (bus.in_vector),
    .elem    (elem),
    .last    (last)
  );

  // Element 0 goes out on the accept edge so writes start the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wcnt         <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      all_finish_q <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      in_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state      <= ST_ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (accept) begin
            state      <= ST_WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= wcnt;
            wcnt       <= wcnt + 1'b1;
          end else begin
            in_ready_q <= enable;
          end
        end
        ST_WRITE: begin
          if (enable) begin
            if (!last) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= wcnt;
              wcnt       <= wcnt + 1'b1;
            end else if (mem_addr_q == ADDR_WIDTH'(TOTAL-1)) begin
              state        <= ST_DONE;
              all_finish_q <= 1'b1;
            end else begin
              state      <= ST_ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: all_finish_q <= 1'b1;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = elem;
  assign bus.all_finish = all_finish_q;

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  logic [ELEMENT_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sum_q <= '0;
    else if (mem_we_q) sum_q <= sum_q + elem;
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_weights_loader.sv
// Randomized self-checking bench for weights_loader against a write-sequence reference model.
module tb_weights_loader;
  import weights_pkg::*;

  localparam int EW    = DEF_ELEMENT_WIDTH;
  localparam int NE    = DEF_NO_OF_RAND_ELEMENTS;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int TOTAL = DEF_NO_OF_ROWS * DEF_NO_OF_COLUMNS;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  weights_loader_if #(.EW(EW), .NE(NE), .AW(AW)) bus();

  weights_loader #(
    .ELEMENT_WIDTH       (EW),
    .NO_OF_RAND_ELEMENTS (NE),
    .NO_OF_ROWS          (DEF_NO_OF_ROWS),
    .NO_OF_COLUMNS       (DEF_NO_OF_COLUMNS),
    .ADDR_WIDTH          (AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: every accepted vector becomes NE writes at consecutive addresses from 0.
  logic [AW+EW-1:0] exp_q[$];
  int               model_addr = 0;
  logic [EW-1:0]    model_sum  = '0;
  int               n_wr       = 0;

  always @(negedge clk) begin
    logic [AW+EW-1:0] e;
    if (reset) begin
      exp_q.delete();
      model_addr = 0;
      model_sum  = '0;
      n_wr       = 0;
    end else begin
      if (bus.mem_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 64'(bus.mem_addr), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.mem_addr), 64'(e[AW+EW-1:EW]));
          chk("wr_data", 64'(bus.mem_wdata), 64'(e[EW-1:0]));
        end
        n_wr++;
      end
      if (bus.in_valid && bus.in_ready && enable) begin
        for (int k = 0; k < NE; k++) begin
          exp_q.push_back({AW'(model_addr), bus.in_vector[k*EW +: EW]});
          model_sum  = model_sum + bus.in_vector[k*EW +: EW];
          model_addr = model_addr + 1;
        end
      end
    end
  end

  function automatic logic [EW*NE-1:0] rnd_vec();
    logic [EW*NE-1:0] r;
    for (int k = 0; k < NE; k++) r[k*EW +: EW] = $urandom();
    return r;
  endfunction

  function automatic logic [EW-1:0] exp_checksum(input logic [EW-1:0] s);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    return s;
`else
    return (s & '0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One edge; reports whether a handshake completed on it.
  task automatic edge_fire(output logic f);
    @(negedge clk);
    f = bus.in_valid & bus.in_ready & enable;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [EW*NE-1:0] v);
    logic f;
    bit   ok;
    ok = 0;
    bus.in_vector = v;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      edge_fire(f);
      if (f) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   64'(bus.in_ready),   0);
    chk({tag, "_mem_we"},     64'(bus.mem_we),     0);
    chk({tag, "_mem_addr"},   64'(bus.mem_addr),   0);
    chk({tag, "_mem_wdata"},  64'(bus.mem_wdata),  0);
    chk({tag, "_all_finish"}, 64'(bus.all_finish), 0);
    chk({tag, "_checksum"},   64'(bus.checksum),   0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [EW*NE-1:0] v;
    logic [EW*NE-1:0] v2;
    logic             f;
    bit               found;
    int               cyc;
    int               first;
    int               fin;
    int               bad;

    reset = 1'b1;
    enable = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vector = '0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    chk("idle_no_ready", 64'(bus.in_ready), 0);

    // Directed vector k+1, with the next vector offered during the write burst.
    enable = 1'b1;
    for (int k = 0; k < NE; k++) v[k*EW +: EW] = EW'(k + 1);
    send(v);
    v2 = rnd_vec();
    bus.in_vector = v2;
    bus.in_valid  = 1'b1;
    for (int c = 1; c <= NE; c++) begin
      if (c > 1) step();
      chk("t1_we",    64'(bus.mem_we),    1);
      chk("t1_addr",  64'(bus.mem_addr),  64'(c - 1));
      chk("t1_data",  64'(bus.mem_wdata), 64'(c));
      chk("t1_ready", 64'(bus.in_ready),  0);
    end
    step();
    chk("t1_ready_back", 64'(bus.in_ready), 1);
    chk("t1_we_off",     64'(bus.mem_we),   0);
    send(v2);

    // Stream until address 163 is on the bus, then reset asynchronously.
    bus.in_vector = rnd_vec();
    bus.in_valid  = 1'b1;
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      edge_fire(f);
      if (f) bus.in_vector = rnd_vec();
      if (bus.mem_we && bus.mem_addr == AW'(163)) found = 1;
    end
    chk("reach_163", 64'(found), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    bus.in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    send(rnd_vec());
    chk("restart_we",   64'(bus.mem_we),   1);
    chk("restart_addr", 64'(bus.mem_addr), 0);
    repeat (NE + 1) step();

    // Pause after element 7 for five cycles.
    v = rnd_vec();
    send(v);
    repeat (7) step();
    chk("pause_pre_we",   64'(bus.mem_we),   1);
    chk("pause_pre_addr", 64'(bus.mem_addr), 64'(NE + 7));
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("pause_gap_we", 64'(bus.mem_we), 0);
    end
    enable = 1'b1;
    step();
    chk("resume_we",   64'(bus.mem_we),    1);
    chk("resume_addr", 64'(bus.mem_addr),  64'(NE + 8));
    chk("resume_data", 64'(bus.mem_wdata), 64'(v[8*EW +: EW]));
    repeat (NE) step();

    // Full matrix, random data, random enable and source gaps.
    pulse_reset();
    enable = 1'b1;
    cyc = 0;
    while (!bus.all_finish && cyc < 20000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_vector = rnd_vec();
        bus.in_valid  = 1'b1;
      end
      edge_fire(f);
      cyc++;
      if (f) bus.in_valid = 1'b0;
      enable = ($urandom_range(0, 99) < 85);
    end
    enable = 1'b1;
    chk("A_finish",   64'(bus.all_finish), 1);
    chk("A_writes",   64'(n_wr),           64'(TOTAL));
    chk("A_q_empty",  64'(exp_q.size()),   0);
    chk("A_checksum", 64'(bus.checksum),   64'(exp_checksum(model_sum)));

    // Full matrix of ones, back-to-back.
    pulse_reset();
    for (int k = 0; k < NE; k++) v[k*EW +: EW] = EW'(1);
    bus.in_vector = v;
    bus.in_valid  = 1'b1;
    enable = 1'b1;
    cyc = 0; first = -1; fin = -1;
    while (cyc < 6000 && fin < 0) begin
      edge_fire(f);
      cyc++;
      if (f && first < 0) first = cyc;
      if (bus.mem_we && bus.mem_addr == AW'(TOTAL - 1)) fin = cyc;
    end
    chk("B_final_seen",  64'(fin >= 0),      1);
    chk("B_span",        64'(fin - first),   64'(TOTAL + TOTAL/NE - 2));
    chk("B_fin_at_last", 64'(bus.all_finish), 0);
    step();
    chk("B_fin_rise",    64'(bus.all_finish), 1);
    chk("B_writes",      64'(n_wr),           64'(TOTAL));
    chk("B_checksum",    64'(bus.checksum),   64'(exp_checksum(EW'(TOTAL))));
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.in_ready || bus.mem_we || !bus.all_finish) bad++;
    end
    chk("B_done_sticky", 64'(bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
